psram_line_fetcher: RTL

//  Upstream feeder for VideoSystem's line buffer, in the clk_psram domain.
//  On each line request:
//   - issues burst reads to the PSRAM controller for one framebuffer line (RGB565, 4 px per 64-bit word);
//   - expands each pixel to RGB888;
//   - writes the pixels into the line buffer through wr_addr/wr_data/wr_en.

---
 rtl/psram_line_fetcher.sv | 220 ++++++++++++++++++++++
 1 files changed

// File: rtl/psram_line_fetcher.sv
// rtl/psram_line_fetcher.sv - fetches one RGB565 framebuffer line from PSRAM and writes it as RGB888 into the line buffer
module psram_line_fetcher #(
  parameter int H_ACTIVE    = 800,
  parameter int V_ACTIVE    = 480,
  parameter int BURST_WORDS = 8,
  parameter int ADDR_W      = 21,
  parameter int FB_BASE     = 0,
  parameter int FIFO_DEPTH  = 16
) (
  input  logic              clk_psram,
  input  logic              rst_n,
  input  logic              line_req,
  input  logic [9:0]        line_idx,
  output logic [9:0]        wr_addr,
  output logic [23:0]       wr_data,
  output logic              wr_en,
  output logic              mem_cmd_valid,
  input  logic              mem_cmd_ready,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_rd_valid,
  input  logic [63:0]       mem_rd_data,
  output logic              busy,
  output logic              line_done,
  output logic              overrun
);

  localparam int WPL   = H_ACTIVE / 4;
  localparam int NB    = WPL / BURST_WORDS;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CRD_W = PTR_W + 1;
  localparam int BST_W = (NB > 1) ? $clog2(NB) : 1;

  localparam logic [CRD_W-1:0]  BURST_CRD  = CRD_W'(BURST_WORDS);
  localparam logic [CRD_W-1:0]  FULL_CRD   = CRD_W'(FIFO_DEPTH);
  localparam logic [BST_W-1:0]  LAST_BURST = BST_W'(NB - 1);
  localparam logic [10:0]       LINE_PIX   = 11'(H_ACTIVE);
  localparam logic [10:0]       LINE_LIM   = 11'(V_ACTIVE);
  localparam logic [ADDR_W-1:0] BURST_STEP = ADDR_W'(BURST_WORDS);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_DRAIN,
    S_BLANK,
    S_DONE
  } state_t;

  state_t            state_q;
  state_t            state_d;
  logic              line_req_q;
  logic              req_edge;
  logic              line_start;
  logic              cmd_fire;
  logic [BST_W-1:0]  burst_q;
  logic [ADDR_W-1:0] line_base;
  logic [CRD_W-1:0]  credits_q;
  logic [CRD_W-1:0]  outst_q;
  logic [63:0]       fifo_mem [FIFO_DEPTH];
  logic [PTR_W:0]    fifo_wptr;
  logic [PTR_W:0]    fifo_rptr;
  logic              fifo_empty;
  logic              fifo_push;
  logic              fifo_pop;
  logic [63:0]       fifo_head;
  logic [63:0]       word_q;
  logic [1:0]        rem_q;
  logic [10:0]       pix_cnt_q;
  logic              emit_blank;
  logic              emit;
  logic [15:0]       pix565;

  function automatic logic [23:0] rgb565_to_888(input logic [15:0] p);
    return {p[15:11], p[15:13], p[10:5], p[10:9], p[4:0], p[4:2]};
  endfunction

  assign req_edge   = line_req & ~line_req_q;
  assign line_start = (state_q == S_IDLE) && req_edge;
  assign line_base  = ADDR_W'(FB_BASE) + ADDR_W'(line_idx) * ADDR_W'(WPL);
  assign busy       = (state_q == S_ISSUE) || (state_q == S_DRAIN) || (state_q == S_BLANK);
  assign line_done  = (state_q == S_DONE);

  assign fifo_empty = (fifo_wptr == fifo_rptr);
  assign fifo_head  = fifo_mem[fifo_rptr[PTR_W-1:0]];
  // Data with no command outstanding is a controller fault and is dropped here.
  assign fifo_push  = mem_rd_valid && (outst_q != '0);
  assign fifo_pop   = (rem_q == 2'd0) && !fifo_empty;
  assign emit_blank = (state_q == S_BLANK) && (pix_cnt_q != LINE_PIX);
  assign emit       = fifo_pop || (rem_q != 2'd0) || emit_blank;

  // Request edge detector; reset high so a level held through reset is not taken as a new request
  always_ff @(posedge clk_psram or negedge rst_n) begin
    if (!rst_n) line_req_q <= 1'b1;
    else        line_req_q <= line_req;
  end

  // Command FSM state register
  always_ff @(posedge clk_psram or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Command FSM next state and read-command handshake
  always_comb begin
    state_d       = state_q;
    mem_cmd_valid = 1'b0;
    cmd_fire      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req_edge) state_d = ({1'b0, line_idx} < LINE_LIM) ? S_ISSUE : S_BLANK;
      end
      S_ISSUE: begin
        // Credits only grow while waiting, so valid cannot drop before ready.
        mem_cmd_valid = (credits_q >= BURST_CRD);
        if (mem_cmd_valid && mem_cmd_ready) begin
          cmd_fire = 1'b1;
          if (burst_q == LAST_BURST) state_d = S_DRAIN;
        end
      end
      S_DRAIN: if (pix_cnt_q == LINE_PIX) state_d = S_DONE;
      S_BLANK: if (pix_cnt_q == LINE_PIX) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Burst index and burst start address for the line in progress
  always_ff @(posedge clk_psram or negedge rst_n) begin
    if (!rst_n) begin
      burst_q  <= '0;
      mem_addr <= '0;
    end else if (line_start) begin
      burst_q  <= '0;
      mem_addr <= line_base;
    end else if (cmd_fire) begin
      burst_q  <= burst_q + BST_W'(1);
      mem_addr <= mem_addr + BURST_STEP;
    end
  end

  // Overrun pulse for a request edge that arrives while a line is still owned by the FSM
  always_ff @(posedge clk_psram or negedge rst_n) begin
    if (!rst_n) overrun <= 1'b0;
    else        overrun <= req_edge && (state_q != S_IDLE);
  end

  // Credit and outstanding-word accounting that keeps the FIFO from overflowing
  always_ff @(posedge clk_psram or negedge rst_n) begin
    if (!rst_n) begin
      credits_q <= FULL_CRD;
      outst_q   <= '0;
    end else begin
      credits_q <= credits_q + CRD_W'(fifo_pop) - (cmd_fire ? BURST_CRD : '0);
      outst_q   <= outst_q + (cmd_fire ? BURST_CRD : '0) - CRD_W'(fifo_push);
    end
  end

  // Word FIFO pointers
  always_ff @(posedge clk_psram or negedge rst_n) begin
    if (!rst_n) begin
      fifo_wptr <= '0;
      fifo_rptr <= '0;
    end else begin
      if (fifo_push) fifo_wptr <= fifo_wptr + (PTR_W+1)'(1);
      if (fifo_pop)  fifo_rptr <= fifo_rptr + (PTR_W+1)'(1);
    end
  end

  // Word FIFO storage
  always_ff @(posedge clk_psram) begin
    if (fifo_push) fifo_mem[fifo_wptr[PTR_W-1:0]] <= mem_rd_data;
  end

  // Unpacker: holds the popped word and counts the pixels still to be emitted from it
  always_ff @(posedge clk_psram or negedge rst_n) begin
    if (!rst_n) begin
      word_q <= '0;
      rem_q  <= 2'd0;
    end else if (fifo_pop) begin
      word_q <= fifo_head;
      rem_q  <= 2'd3;
    end else if (rem_q != 2'd0) begin
      rem_q <= rem_q - 2'd1;
    end
  end

  // Pixel select: px0 straight from the FIFO head on a pop, px1..px3 from the held word
  always_comb begin
    pix565 = 16'h0000;
    if (fifo_pop) begin
      pix565 = fifo_head[15:0];
    end else begin
      case (rem_q)
        2'd3:    pix565 = word_q[31:16];
        2'd2:    pix565 = word_q[47:32];
        2'd1:    pix565 = word_q[63:48];
        default: pix565 = 16'h0000;
      endcase
    end
  end

  // Registered line-buffer write port and per-line pixel counter
  always_ff @(posedge clk_psram or negedge rst_n) begin
    if (!rst_n) begin
      wr_en     <= 1'b0;
      wr_data   <= '0;
      wr_addr   <= '0;
      pix_cnt_q <= '0;
    end else begin
      wr_en <= emit;
      if (line_start) begin
        pix_cnt_q <= '0;
      end else if (emit) begin
        wr_data   <= emit_blank ? 24'h000000 : rgb565_to_888(pix565);
        wr_addr   <= pix_cnt_q[9:0];
        pix_cnt_q <= pix_cnt_q + 11'd1;
      end
    end
  end

endmodule
